// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the pipelined fetch stage.
// Width defaults, reset vector, counter widths and FSM states.
package pc_fetch_pkg;

   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned INST_W_DEF = 32;
   localparam logic [31:0] RESET_VEC_DEF = 32'hbfc00000;

   localparam int unsigned CNT_W  = 3;
   localparam int unsigned DROP_W = 8;

   typedef enum logic {
      OFF = 1'b0,
      RUN = 1'b1
   } state_e;

endpackage

// File: rtl/pc_fetch_fifo.sv
// Small synchronous FIFO with clear and occupancy count.
// Used for both the request address tags and buffered responses.
import pc_fetch_pkg::*;

module fetch_fifo #(
   parameter int unsigned W     = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic [W-1:0]     wdata_i,
   input  logic             pop_i,
   output logic [W-1:0]     rdata_o,
   output logic [CNT_W-1:0] cnt_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [AW-1:0]    rd_q, wr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             full, empty, do_push, do_pop;

   function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (cnt_q == CNT_W'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_pop  = pop_i & ~empty;
   // a full FIFO may still accept a write in the cycle its head leaves
   assign do_push = push_i & (~full | do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else if (clr_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= inc(wr_q);
         if (do_pop)  rd_q <= inc(rd_q);
         cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clr_i) mem_q[wr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_q];
   assign cnt_o   = cnt_q;

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push_i && !clr_i && full && !do_pop));

endmodule

// File: rtl/pc_fetch.sv
// Fetch PC generator with pipelined imem handshake, redirect
// handling, dropped-response tracking and a decode-side buffer.
import pc_fetch_pkg::*;

module pc_fetch #(
   parameter int unsigned       ADDR_W    = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF),
   parameter int unsigned       STRIDE    = 4,
   parameter int unsigned       MAX_OUTST = 2,
   parameter int unsigned       INST_W    = INST_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic [ADDR_W-1:0] flush_addr,
   input  logic              branch,
   input  logic [ADDR_W-1:0] b_addr,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [INST_W-1:0] imem_rdata,
   output logic              ce,
   output logic              inst_valid,
   output logic [INST_W-1:0] inst,
   output logic [ADDR_W-1:0] inst_pc
);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
   logic [DROP_W-1:0]   drop_q, drop_d;
   logic                iv_q, iv_d;
   logic [INST_W-1:0]   inst_q, inst_d;
   logic [ADDR_W-1:0]   ipc_q, ipc_d;

   logic                run, redirect, credit, fire, take;
   logic                d_push, d_pop, d_nempty;
   logic [ADDR_W-1:0]   tag_head;
   logic [CNT_W-1:0]    tag_cnt, d_cnt;
   logic [ADDR_W+INST_W-1:0] d_head;

   assign run      = (state_q == RUN);
   assign redirect = flush | (branch & ~stall);
   assign credit   = ({1'b0, out_cnt_q} + {1'b0, d_cnt})
                     < (CNT_W + 1)'(MAX_OUTST);
   assign imem_req  = run & ~stall & credit & ~redirect;
   assign imem_addr = pc_q;
   assign fire      = imem_req & imem_gnt;
   // killed responses drain first; a response racing a redirect dies too
   assign take      = imem_rvalid & (drop_q == '0) & ~redirect;
   assign d_nempty  = (d_cnt != '0);
   assign d_pop     = ~stall & ~redirect & d_nempty;
   assign d_push    = take & (stall | d_nempty);

   fetch_fifo #(.W(ADDR_W), .DEPTH(MAX_OUTST)) u_tag (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (redirect),
      .push_i  (fire),
      .wdata_i (pc_q),
      .pop_i   (take),
      .rdata_o (tag_head),
      .cnt_o   (tag_cnt)
   );

   fetch_fifo #(.W(ADDR_W + INST_W), .DEPTH(MAX_OUTST)) u_data (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (redirect),
      .push_i  (d_push),
      .wdata_i ({tag_head, imem_rdata}),
      .pop_i   (d_pop),
      .rdata_o (d_head),
      .cnt_o   (d_cnt)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         OFF:     state_d = RUN;
         RUN:     state_d = RUN;
         default: state_d = OFF;
      endcase
   end

   assign ce = run;

   always_comb begin
      pc_d      = pc_q;
      out_cnt_d = out_cnt_q;
      drop_d    = drop_q;
      iv_d      = iv_q;
      inst_d    = inst_q;
      ipc_d     = ipc_q;
      if (redirect) begin
         pc_d      = flush ? flush_addr : b_addr;
         out_cnt_d = '0;
         drop_d    = drop_q + DROP_W'(out_cnt_q)
                     - DROP_W'(imem_rvalid);
         iv_d      = 1'b0;
      end else begin
         if (fire) pc_d = pc_q + ADDR_W'(STRIDE);
         out_cnt_d = out_cnt_q + CNT_W'(fire) - CNT_W'(take);
         if (imem_rvalid && drop_q != '0) drop_d = drop_q - 1'b1;
         if (!stall) begin
            if (d_nempty) begin
               iv_d   = 1'b1;
               ipc_d  = d_head[ADDR_W+INST_W-1:INST_W];
               inst_d = d_head[INST_W-1:0];
            end else if (take) begin
               iv_d   = 1'b1;
               ipc_d  = tag_head;
               inst_d = imem_rdata;
            end else begin
               iv_d   = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= OFF;
         pc_q      <= RESET_VEC;
         out_cnt_q <= '0;
         drop_q    <= '0;
         iv_q      <= 1'b0;
         inst_q    <= '0;
         ipc_q     <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         out_cnt_q <= out_cnt_d;
         drop_q    <= drop_d;
         iv_q      <= iv_d;
         inst_q    <= inst_d;
         ipc_q     <= ipc_d;
      end
   end

   assign inst_valid = iv_q;
   assign inst       = inst_q;
   assign inst_pc    = ipc_q;

   a_rvalid_legal: assert property (@(posedge clk) disable iff (rst)
      imem_rvalid |-> (out_cnt_q != '0 || drop_q != '0));

   a_tag_sync: assert property (@(posedge clk) disable iff (rst)
      tag_cnt == out_cnt_q);

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: issue, bypass, redirect drop,
// stall buffering, PC wrap and asynchronous reset.
module tb_pc_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        flush;
   logic [31:0] flush_addr;
   logic        branch;
   logic [31:0] b_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        ce;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;

   int n_vec = 0;
   int n_bad = 0;

   pc_fetch dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .flush       (flush),
      .flush_addr  (flush_addr),
      .branch      (branch),
      .b_addr      (b_addr),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .ce          (ce),
      .inst_valid  (inst_valid),
      .inst        (inst),
      .inst_pc     (inst_pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic resp(input logic v, input logic [31:0] a);
      imem_rvalid = v;
      imem_rdata  = v ? ~a : 32'h0;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0; branch = 1'b0;
      flush_addr = 32'h0; b_addr = 32'h0;
      imem_gnt = 1'b0; resp(1'b0, 32'h0);
      #2;
      chk("rst_ce", {31'b0, ce}, 32'h0);
      chk("rst_iv", {31'b0, inst_valid}, 32'h0);
      chk("rst_inst", inst, 32'h0);
      chk("rst_ipc", inst_pc, 32'h0);
      chk("rst_req", {31'b0, imem_req}, 32'h0);

      // release reset between edges; first edge with rst low is E0
      next(); rst = 1'b0; #1;
      chk("pre_e0_ce", {31'b0, ce}, 32'h0);
      next(); imem_gnt = 1'b1; #1;
      chk("e0_ce", {31'b0, ce}, 32'h1);
      chk("e0_req", {31'b0, imem_req}, 32'h1);
      chk("e0_addr", imem_addr, 32'hbfc00000);

      next(); resp(1'b1, 32'hbfc00000); #1;
      chk("seq_addr1", imem_addr, 32'hbfc00004);
      chk("seq_iv0", {31'b0, inst_valid}, 32'h0);
      next(); resp(1'b1, 32'hbfc00004); #1;
      chk("seq_ipc0", inst_pc, 32'hbfc00000);
      chk("seq_inst0", inst, ~32'hbfc00000);
      chk("seq_addr2", imem_addr, 32'hbfc00008);
      next(); resp(1'b1, 32'hbfc00008); #1;
      chk("seq_ipc1", inst_pc, 32'hbfc00004);
      chk("seq_iv1", {31'b0, inst_valid}, 32'h1);
      chk("seq_addr3", imem_addr, 32'hbfc0000c);
      next(); resp(1'b0, 32'h0); #1;
      chk("seq_ipc2", inst_pc, 32'hbfc00008);
      chk("seq_addr4", imem_addr, 32'hbfc00010);

      // two outstanding (0c, 10): credit exhausted, then branch
      next(); branch = 1'b1; b_addr = 32'h80000100; #1;
      chk("credit_req", {31'b0, imem_req}, 32'h0);
      chk("credit_iv", {31'b0, inst_valid}, 32'h0);
      next(); branch = 1'b0; resp(1'b1, 32'hbfc0000c); #1;
      chk("br_addr", imem_addr, 32'h80000100);
      chk("br_req", {31'b0, imem_req}, 32'h1);
      next(); resp(1'b1, 32'hbfc00010); #1;
      chk("drop1_iv", {31'b0, inst_valid}, 32'h0);
      chk("br_addr2", imem_addr, 32'h80000104);
      next(); resp(1'b1, 32'h80000100); #1;
      chk("drop2_iv", {31'b0, inst_valid}, 32'h0);
      chk("br_full_req", {31'b0, imem_req}, 32'h0);
      next(); imem_gnt = 1'b0; resp(1'b1, 32'h80000104); #1;
      chk("br_ipc0", inst_pc, 32'h80000100);
      chk("br_inst0", inst, ~32'h80000100);
      chk("br_iv0", {31'b0, inst_valid}, 32'h1);
      chk("br_addr3", imem_addr, 32'h80000108);

      // flush and branch together: flush wins
      next(); resp(1'b0, 32'h0);
      flush = 1'b1; flush_addr = 32'hbfc00380;
      branch = 1'b1; b_addr = 32'h80000200; #1;
      chk("br_ipc1", inst_pc, 32'h80000104);
      chk("fl_req", {31'b0, imem_req}, 32'h0);
      next(); flush = 1'b0; branch = 1'b0; #1;
      chk("fl_addr", imem_addr, 32'hbfc00380);
      chk("fl_iv", {31'b0, inst_valid}, 32'h0);
      stall = 1'b1; branch = 1'b1; b_addr = 32'h12345678; #1;
      chk("stbr_req", {31'b0, imem_req}, 32'h0);
      next(); branch = 1'b0; stall = 1'b0; imem_gnt = 1'b1; #1;
      chk("stbr_addr", imem_addr, 32'hbfc00380);
      chk("stbr_req2", {31'b0, imem_req}, 32'h1);
      next(); #1;
      chk("st_addr1", imem_addr, 32'hbfc00384);

      // five stall cycles, two responses buffered
      next(); stall = 1'b1; imem_gnt = 1'b0;
      resp(1'b1, 32'hbfc00380); #1;
      chk("st_req1", {31'b0, imem_req}, 32'h0);
      next(); resp(1'b1, 32'hbfc00384); #1;
      chk("st_req2", {31'b0, imem_req}, 32'h0);
      chk("st_iv2", {31'b0, inst_valid}, 32'h0);
      next(); resp(1'b0, 32'h0); #1;
      chk("st_req3", {31'b0, imem_req}, 32'h0);
      chk("st_ipc3", inst_pc, 32'h80000104);
      next(); #1;
      chk("st_iv4", {31'b0, inst_valid}, 32'h0);
      next(); #1;
      chk("st_ipc5", inst_pc, 32'h80000104);
      next(); stall = 1'b0; #1;
      chk("rel_req", {31'b0, imem_req}, 32'h0);
      chk("rel_iv", {31'b0, inst_valid}, 32'h0);
      next(); #1;
      chk("rel_ipc0", inst_pc, 32'hbfc00380);
      chk("rel_inst0", inst, ~32'hbfc00380);
      chk("rel_req2", {31'b0, imem_req}, 32'h1);
      next(); #1;
      chk("rel_ipc1", inst_pc, 32'hbfc00384);
      chk("rel_iv1", {31'b0, inst_valid}, 32'h1);
      next(); #1;
      chk("rel_iv2", {31'b0, inst_valid}, 32'h0);

      // PC wraps silently past the top of the address space
      flush = 1'b1; flush_addr = 32'hfffffffc;
      next(); flush = 1'b0; imem_gnt = 1'b1; #1;
      chk("wr_addr0", imem_addr, 32'hfffffffc);
      next(); #1;
      chk("wr_addr1", imem_addr, 32'h00000000);
      chk("wr_req1", {31'b0, imem_req}, 32'h1);

      // asynchronous reset with two requests outstanding
      next(); imem_gnt = 1'b0; rst = 1'b1; #1;
      chk("ar_ce", {31'b0, ce}, 32'h0);
      chk("ar_iv", {31'b0, inst_valid}, 32'h0);
      chk("ar_inst", inst, 32'h0);
      chk("ar_ipc", inst_pc, 32'h0);
      chk("ar_req", {31'b0, imem_req}, 32'h0);
      next(); rst = 1'b0;
      next(); imem_gnt = 1'b1; #1;
      chk("ar_ce2", {31'b0, ce}, 32'h1);
      chk("ar_addr", imem_addr, 32'hbfc00000);
      next(); imem_gnt = 1'b0; resp(1'b1, 32'hbfc00000); #1;
      next(); resp(1'b0, 32'h0); #1;
      chk("ar_iv2", {31'b0, inst_valid}, 32'h1);
      chk("ar_ipc2", inst_pc, 32'hbfc00000);
      chk("ar_inst2", inst, ~32'hbfc00000);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule
